// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and types for the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_nibs(input int width);
    return width / NIB_W;
  endfunction
endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// 4-bit carry-lookahead adder slice: all carries derived from generate/propagate terms.
module cla4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_cin,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_cout
);
  logic [NIB_W-1:0] w_g, w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[NIB_W-1:0];
  assign o_cout = w_c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract that reuses one 4-bit CLA slice, one nibble per cycle, LSB first.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int N  = num_nibs(WIDTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_carry, r_a_msb, r_b_msb;
  logic             r_out_cout, r_out_ovf;

  logic                     w_accept, w_out_hs, w_last;
  logic [WIDTH-1:0]         w_b_eff, w_sum_next;
  logic [N-1:0][NIB_W-1:0]  w_a_nibs, w_b_nibs;
  logic [NIB_W-1:0]         w_s;
  logic                     w_c4;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_b_eff  = in_sub ? ~in_b : in_b;

  assign w_a_nibs = r_a;
  assign w_b_nibs = r_b;

  cla4_slice u_cla (
    .i_a    (w_a_nibs[r_cnt]),
    .i_b    (w_b_nibs[r_cnt]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c4)
  );

  // New nibble enters at the top so the LSB nibble ends up at the bottom after N shifts.
  generate
    if (WIDTH == NIB_W) begin : g_one_nib
      assign w_sum_next = w_s;
    end else begin : g_multi_nib
      assign w_sum_next = {w_s, r_sum[WIDTH-1:NIB_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_last)   w_next = DONE;
      DONE:    if (w_out_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= w_b_eff;
      r_carry <= in_sub ? 1'b1 : in_cin;
      r_cnt   <= '0;
      r_a_msb <= in_a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == CALC) begin
      r_carry <= w_c4;
      r_sum   <= w_sum_next;
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        r_out_sum  <= w_sum_next;
        r_out_cout <= w_c4;
        // Signed overflow: operands agree in sign but the result does not.
        r_out_ovf  <= (r_a_msb == r_b_msb) && (w_s[NIB_W-1] != r_a_msb);
      end
    end
  end
endmodule
